// File: rtl/id_ex_operand_stage_pkg.sv
// Shared types and constants for the ID/EX operand stage.
// ALU opcodes, datapath widths and the held-entry bundle.
package id_ex_operand_stage_pkg;

  localparam int NBITS = 32;
  localparam int OPW   = 4;
  localparam int RAW   = 5;

  localparam logic [RAW-1:0] REG_ZERO = '0;

  localparam logic [OPW-1:0] ALU_AND      = 4'd0;
  localparam logic [OPW-1:0] ALU_OR       = 4'd1;
  localparam logic [OPW-1:0] ALU_NOR      = 4'd2;
  localparam logic [OPW-1:0] ALU_ADD      = 4'd3;
  localparam logic [OPW-1:0] ALU_SUB      = 4'd4;
  localparam logic [OPW-1:0] ALU_INC      = 4'd9;
  localparam logic [OPW-1:0] ALU_MULTPLUS = 4'd10;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  typedef struct packed {
    logic [OPW-1:0]   op;
    logic [NBITS-1:0] a;
    logic [NBITS-1:0] b;
    logic [RAW-1:0]   rd;
    logic             rw;
    logic [RAW-1:0]   rs;
    logic [RAW-1:0]   rt;
    logic             use_imm;
  } id_ex_t;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// ID -> EX handshake bus plus forwarding sources.
// slave is the stage side, master the driving side.
interface id_ex_operand_stage_if;
  import id_ex_operand_stage_pkg::*;

  logic             id_valid;
  logic             id_ready;
  logic [OPW-1:0]   id_alu_op;
  logic [RAW-1:0]   id_rs_addr;
  logic [RAW-1:0]   id_rt_addr;
  logic [NBITS-1:0] id_rs_data;
  logic [NBITS-1:0] id_rt_data;
  logic [NBITS-1:0] id_imm;
  logic             id_use_imm;
  logic [RAW-1:0]   id_rd_addr;
  logic             id_reg_write;

  logic             exmem_reg_write;
  logic [RAW-1:0]   exmem_rd_addr;
  logic [NBITS-1:0] exmem_result;
  logic             memwb_reg_write;
  logic [RAW-1:0]   memwb_rd_addr;
  logic [NBITS-1:0] memwb_result;

  logic             ex_valid;
  logic             ex_ready;
  logic [OPW-1:0]   ex_alu_op;
  logic [NBITS-1:0] ex_a;
  logic [NBITS-1:0] ex_b;
  logic [RAW-1:0]   ex_rd_addr;
  logic             ex_reg_write;

  modport slave (
    input  id_valid, id_alu_op,
    input  id_rs_addr, id_rt_addr,
    input  id_rs_data, id_rt_data,
    input  id_imm, id_use_imm,
    input  id_rd_addr, id_reg_write,
    input  exmem_reg_write, exmem_rd_addr,
    input  exmem_result,
    input  memwb_reg_write, memwb_rd_addr,
    input  memwb_result,
    input  ex_ready,
    output id_ready,
    output ex_valid, ex_alu_op,
    output ex_a, ex_b,
    output ex_rd_addr, ex_reg_write
  );

  modport master (
    output id_valid, id_alu_op,
    output id_rs_addr, id_rt_addr,
    output id_rs_data, id_rt_data,
    output id_imm, id_use_imm,
    output id_rd_addr, id_reg_write,
    output exmem_reg_write, exmem_rd_addr,
    output exmem_result,
    output memwb_reg_write, memwb_rd_addr,
    output memwb_result,
    output ex_ready,
    input  id_ready,
    input  ex_valid, ex_alu_op,
    input  ex_a, ex_b,
    input  ex_rd_addr, ex_reg_write
  );

endinterface

// File: rtl/id_ex_operand_stage_fwd_select.sv
// RAW forwarding mux: EX/MEM beats MEM/WB,
// register zero always reads the register file value.
module id_ex_operand_stage_fwd_select
  import id_ex_operand_stage_pkg::*;
(
  input  logic [RAW-1:0]   addr,
  input  logic [NBITS-1:0] rf,
  input  logic             exmem_we,
  input  logic [RAW-1:0]   exmem_rd,
  input  logic [NBITS-1:0] exmem_res,
  input  logic             memwb_we,
  input  logic [RAW-1:0]   memwb_rd,
  input  logic [NBITS-1:0] memwb_res,
  output logic [NBITS-1:0] data
);

  logic nz;
  logic hit_ex;
  logic hit_wb;

  // Pick the youngest matching producer.
  always_comb begin
    nz     = (addr != REG_ZERO);
    hit_ex = nz & exmem_we & (exmem_rd == addr);
    hit_wb = nz & memwb_we & (memwb_rd == addr);
    data   = rf;
    unique case (1'b1)
      hit_ex:            data = exmem_res;
      hit_wb & ~hit_ex:  data = memwb_res;
      default:           data = rf;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// Single-entry ID/EX register feeding the ALU,
// with operand forwarding, snoop-while-stalled and stall counter.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int CNTW = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  id_ex_operand_stage_if.slave bus,
  output logic [CNTW-1:0]     stall_cnt
);

  state_e            state_q, state_d;
  id_ex_t            entry_q, entry_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  logic              load;
  logic              stall;
  logic [NBITS-1:0]  ld_a, ld_b;
  logic [NBITS-1:0]  sn_a, sn_b;

  id_ex_operand_stage_fwd_select u_ld_a (
    .addr(bus.id_rs_addr), .rf(bus.id_rs_data),
    .exmem_we(bus.exmem_reg_write),
    .exmem_rd(bus.exmem_rd_addr),
    .exmem_res(bus.exmem_result),
    .memwb_we(bus.memwb_reg_write),
    .memwb_rd(bus.memwb_rd_addr),
    .memwb_res(bus.memwb_result),
    .data(ld_a)
  );

  id_ex_operand_stage_fwd_select u_ld_b (
    .addr(bus.id_rt_addr), .rf(bus.id_rt_data),
    .exmem_we(bus.exmem_reg_write),
    .exmem_rd(bus.exmem_rd_addr),
    .exmem_res(bus.exmem_result),
    .memwb_we(bus.memwb_reg_write),
    .memwb_rd(bus.memwb_rd_addr),
    .memwb_res(bus.memwb_result),
    .data(ld_b)
  );

  id_ex_operand_stage_fwd_select u_sn_a (
    .addr(entry_q.rs), .rf(entry_q.a),
    .exmem_we(bus.exmem_reg_write),
    .exmem_rd(bus.exmem_rd_addr),
    .exmem_res(bus.exmem_result),
    .memwb_we(bus.memwb_reg_write),
    .memwb_rd(bus.memwb_rd_addr),
    .memwb_res(bus.memwb_result),
    .data(sn_a)
  );

  id_ex_operand_stage_fwd_select u_sn_b (
    .addr(entry_q.rt), .rf(entry_q.b),
    .exmem_we(bus.exmem_reg_write),
    .exmem_rd(bus.exmem_rd_addr),
    .exmem_res(bus.exmem_result),
    .memwb_we(bus.memwb_reg_write),
    .memwb_rd(bus.memwb_rd_addr),
    .memwb_res(bus.memwb_result),
    .data(sn_b)
  );

  // Handshake, next state, capture/snoop and stall counting.
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;

    bus.id_ready = (state_q == EMPTY) | bus.ex_ready | flush;
    load  = bus.id_valid & bus.id_ready & ~flush;
    stall = (state_q == FULL) & ~bus.ex_ready & ~flush;

    if (flush) begin
      state_d = EMPTY;
    end else if (load) begin
      state_d         = FULL;
      entry_d.op      = bus.id_alu_op;
      entry_d.a       = ld_a;
      entry_d.b       = bus.id_use_imm ? bus.id_imm : ld_b;
      entry_d.rd      = bus.id_rd_addr;
      entry_d.rw      = bus.id_reg_write;
      entry_d.rs      = bus.id_rs_addr;
      entry_d.rt      = bus.id_rt_addr;
      entry_d.use_imm = bus.id_use_imm;
    end else if (stall) begin
      entry_d.a = sn_a;
      if (!entry_q.use_imm) entry_d.b = sn_b;
    end else if (state_q == FULL) begin
      state_d = EMPTY;
    end

    if (stall && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  // State, entry and counter registers; reset overrides all.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      entry_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ex_valid     = (state_q == FULL);
  assign bus.ex_alu_op    = entry_q.op;
  assign bus.ex_a         = entry_q.a;
  assign bus.ex_b         = entry_q.b;
  assign bus.ex_rd_addr   = entry_q.rd;
  assign bus.ex_reg_write = entry_q.rw;
  assign stall_cnt        = cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed literal checks
// plus random traffic against a behavioural model.
module tb_id_ex_operand_stage;
  import id_ex_operand_stage_pkg::*;

  localparam int TCNTW  = 4;
  localparam int CNTMAX = (1 << TCNTW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic [TCNTW-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit run      = 1'b0;

  id_ex_operand_stage_if bus ();

  id_ex_operand_stage #(.CNTW(TCNTW)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .bus(bus.slave),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Model: one held instruction, its operands and a stall tally.
  bit       m_valid = 0;
  int       m_op = 0, m_rd = 0, m_rw = 0;
  int       m_rs = 0, m_rt = 0, m_ui = 0;
  int       m_cnt = 0;
  bit [31:0] m_a = 0, m_b = 0;

  function automatic bit [31:0] fwd(int addr, bit [31:0] rf);
    if (addr == 0) return rf;
    if (bus.exmem_reg_write && int'(bus.exmem_rd_addr) == addr)
      return bus.exmem_result;
    if (bus.memwb_reg_write && int'(bus.memwb_rd_addr) == addr)
      return bus.memwb_result;
    return rf;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit held_stalled;
    bit accept;
    if (reset) begin
      m_valid = 0; m_op = 0; m_rd = 0; m_rw = 0;
      m_rs = 0; m_rt = 0; m_ui = 0;
      m_a = 0; m_b = 0; m_cnt = 0;
    end else begin
      held_stalled = m_valid && !bus.ex_ready && !flush;
      accept = bus.id_valid && !flush &&
               (!m_valid || bus.ex_ready);
      if (held_stalled) begin
        if (m_cnt < CNTMAX) m_cnt = m_cnt + 1;
        m_a = fwd(m_rs, m_a);
        if (m_ui == 0) m_b = fwd(m_rt, m_b);
      end
      if (flush) begin
        m_valid = 0;
      end else if (accept) begin
        m_valid = 1;
        m_op = int'(bus.id_alu_op);
        m_rd = int'(bus.id_rd_addr);
        m_rw = int'(bus.id_reg_write);
        m_rs = int'(bus.id_rs_addr);
        m_rt = int'(bus.id_rt_addr);
        m_ui = int'(bus.id_use_imm);
        m_a  = fwd(m_rs, bus.id_rs_data);
        m_b  = bus.id_use_imm ? bus.id_imm
                              : fwd(m_rt, bus.id_rt_data);
      end else if (bus.ex_ready) begin
        m_valid = 0;
      end
    end
  end

  // Compare every cycle, mid-cycle.
  always @(negedge clk) begin
    if (run) begin
      chk("id_ready", 32'(bus.id_ready),
          32'(!m_valid || bus.ex_ready || flush));
      chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
      chk("ex_alu_op", 32'(bus.ex_alu_op), 32'(m_op));
      chk("ex_a", bus.ex_a, m_a);
      chk("ex_b", bus.ex_b, m_b);
      chk("ex_rd_addr", 32'(bus.ex_rd_addr), 32'(m_rd));
      chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(m_rw));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic no_fwd();
    bus.exmem_reg_write = 0;
    bus.exmem_rd_addr   = 0;
    bus.exmem_result    = 0;
    bus.memwb_reg_write = 0;
    bus.memwb_rd_addr   = 0;
    bus.memwb_result    = 0;
  endtask

  task automatic ld(input logic [3:0] op,
                    input logic [4:0] rs, input logic [31:0] rsd,
                    input logic [4:0] rt, input logic [31:0] rtd,
                    input logic ui, input logic [31:0] imm);
    bus.id_valid     = 1;
    bus.id_alu_op    = op;
    bus.id_rs_addr   = rs;
    bus.id_rs_data   = rsd;
    bus.id_rt_addr   = rt;
    bus.id_rt_data   = rtd;
    bus.id_use_imm   = ui;
    bus.id_imm       = imm;
    bus.id_rd_addr   = 5'd3;
    bus.id_reg_write = 1;
  endtask

  initial begin
    reset = 1; flush = 0;
    bus.ex_ready = 1;
    ld(ALU_AND, 0, 0, 0, 0, 0, 0);
    bus.id_valid = 0;
    no_fwd();
    step();
    reset = 0;
    run = 1;

    // basic capture
    ld(ALU_ADD, 8, 5, 9, 7, 0, 0);
    step();
    chk("basic_valid", 32'(bus.ex_valid), 1);
    chk("basic_a", bus.ex_a, 5);
    chk("basic_b", bus.ex_b, 7);
    chk("basic_op", 32'(bus.ex_alu_op), 3);
    chk("basic_cnt", 32'(stall_cnt), 0);

    // forwarding priority
    ld(ALU_ADD, 8, 32'h11, 9, 7, 0, 0);
    bus.exmem_reg_write = 1; bus.exmem_rd_addr = 8;
    bus.exmem_result = 32'h100;
    bus.memwb_reg_write = 1; bus.memwb_rd_addr = 8;
    bus.memwb_result = 32'h200;
    step();
    chk("prio_exmem", bus.ex_a, 32'h100);
    bus.exmem_reg_write = 0;
    step();
    chk("prio_memwb", bus.ex_a, 32'h200);
    ld(ALU_ADD, 0, 0, 9, 7, 0, 0);
    bus.exmem_reg_write = 1; bus.exmem_rd_addr = 0;
    bus.memwb_rd_addr = 0;
    step();
    chk("prio_r0", bus.ex_a, 0);

    // immediate B ignores forwarding
    ld(ALU_ADD, 8, 1, 9, 7, 1, 32'hFFFF_FFFC);
    bus.exmem_reg_write = 1; bus.exmem_rd_addr = 9;
    bus.exmem_result = 32'h123;
    step();
    chk("imm_b", bus.ex_b, 32'hFFFF_FFFC);
    no_fwd();

    // stall and snoop
    bus.id_valid = 0;
    reset = 1; step(); reset = 0;
    ld(ALU_SUB, 10, 1, 11, 2, 0, 0);
    step();
    bus.id_valid = 0; bus.ex_ready = 0;
    #1 chk("stall_ready", 32'(bus.id_ready), 0);
    step();
    bus.memwb_reg_write = 1; bus.memwb_rd_addr = 10;
    bus.memwb_result = 32'h55;
    step();
    no_fwd();
    step();
    chk("snoop_a", bus.ex_a, 32'h55);
    chk("snoop_b", bus.ex_b, 2);
    chk("snoop_op", 32'(bus.ex_alu_op), 32'(ALU_SUB));
    chk("stall_cnt3", 32'(stall_cnt), 3);
    bus.ex_ready = 1;
    step();
    chk("consumed", 32'(bus.ex_valid), 0);

    // back-to-back then flush
    for (int i = 0; i < 4; i++) begin
      ld(ALU_OR, 5'd12, 32'h10 + i, 5'd13, 0, 0, 0);
      step();
      chk("b2b_valid", 32'(bus.ex_valid), 1);
      chk("b2b_a", bus.ex_a, 32'h10 + i);
    end
    ld(ALU_OR, 5'd12, 32'h99, 5'd13, 0, 0, 0);
    flush = 1;
    step();
    flush = 0; bus.id_valid = 0;
    chk("flush_valid", 32'(bus.ex_valid), 0);
    chk("flush_hold", bus.ex_a, 32'h13);

    // reset mid-stall
    ld(ALU_INC, 5'd4, 32'h77, 5'd5, 32'h88, 0, 0);
    step();
    bus.id_valid = 0; bus.ex_ready = 0;
    step(); step();
    reset = 1;
    step();
    reset = 0;
    chk("rst_valid", 32'(bus.ex_valid), 0);
    chk("rst_a", bus.ex_a, 0);
    chk("rst_b", bus.ex_b, 0);
    chk("rst_op", 32'(bus.ex_alu_op), 0);
    chk("rst_rw", 32'(bus.ex_reg_write), 0);
    chk("rst_cnt", 32'(stall_cnt), 0);

    // saturation
    bus.ex_ready = 1;
    ld(ALU_MULTPLUS, 1, 1, 2, 2, 0, 0);
    step();
    bus.id_valid = 0; bus.ex_ready = 0;
    repeat (20) step();
    chk("sat_cnt", 32'(stall_cnt), 15);
    bus.ex_ready = 1;
    reset = 1; step(); reset = 0;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 15) == 0);
      bus.ex_ready = ($urandom_range(0, 2) != 0);
      ld(4'($urandom_range(0, 15)),
         5'($urandom_range(0, 3)), $urandom,
         5'($urandom_range(0, 3)), $urandom,
         1'($urandom_range(0, 1)), $urandom);
      bus.id_valid = 1'($urandom_range(0, 1));
      bus.id_rd_addr = 5'($urandom);
      bus.id_reg_write = 1'($urandom);
      bus.exmem_reg_write = 1'($urandom);
      bus.exmem_rd_addr = 5'($urandom_range(0, 3));
      bus.exmem_result = $urandom;
      bus.memwb_reg_write = 1'($urandom);
      bus.memwb_rd_addr = 5'($urandom_range(0, 3));
      bus.memwb_result = $urandom;
      step();
    end

    @(negedge clk);
    run = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Single-entry pipeline register that sits directly upstream of the 32-bit ALU.
- Captures the decoded operation and operands from decode (ID) and resolves RAW hazards by forwarding from the EX/MEM and MEM/WB result paths.
- Presents registered ALUOperation/A/B to the ALU under a valid/ready handshake, with flush support and a saturating stall counter.

Parameters:
- NBITS, 32, datapath width of operands and forwarded results.
- OPW, 4, width of the ALU operation code; matches the ALU encoding (AND=0, OR=1, NOR=2, ADD=3, SUB=4, INC=9, MULTPLUS=10).
- RAW, 5, register-address width.
- CNTW, 16, stall-counter width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard the held entry and any incoming ID entry this cycle.
- id_valid  in  1  ID entry offered.
- id_ready  out  1  stage can accept this cycle.
- id_alu_op  in  OPW  ALU operation code.
- id_rs_addr  in  RAW  A-source register.
- id_rt_addr  in  RAW  B-source register.
- id_rs_data  in  NBITS  register-file value for rs.
- id_rt_data  in  NBITS  register-file value for rt.
- id_imm  in  NBITS  sign/zero-extended immediate.
- id_use_imm  in  1  B comes from id_imm, not rt.
- id_rd_addr  in  RAW  destination register.
- id_reg_write  in  1  instruction writes rd.
- exmem_reg_write  in  1  EX/MEM forwarding-source enable.
- exmem_rd_addr  in  RAW  EX/MEM forwarding-source address.
- exmem_result  in  NBITS  EX/MEM forwarding-source value.
- memwb_reg_write  in  1  MEM/WB forwarding-source enable.
- memwb_rd_addr  in  RAW  MEM/WB forwarding-source address.
- memwb_result  in  NBITS  MEM/WB forwarding-source value.
- ex_valid  out  1  entry held for the ALU.
- ex_ready  in  1  ALU/EX consumes the entry this cycle.
- ex_alu_op  out  OPW  registered operation code.
- ex_a  out  NBITS  registered operand A.
- ex_b  out  NBITS  registered operand B.
- ex_rd_addr  out  RAW  registered destination register.
- ex_reg_write  out  1  registered write-enable.
- stall_cnt  out  CNTW  count of cycles with ex_valid=1 and ex_ready=0.

Behaviour:
- Reset (synchronous, active-high, wins over all other inputs): state EMPTY; every ex_* output=0; stall_cnt=0. Reset asserted mid-stall drops the held entry.
- States: EMPTY (ex_valid=0), FULL (ex_valid=1).
- id_ready = (state==EMPTY) | ex_ready | flush. This is combinational, with no dependency on id_valid.
- Load condition: id_valid & id_ready & !flush. Latency is 1 cycle: the entry appears on ex_* at the edge after acceptance.
- Transitions:
  - EMPTY -> FULL on load.
  - FULL with ex_ready -> FULL on load (back-to-back, no bubble), else -> EMPTY.
  - FULL with !ex_ready -> FULL; hold and snoop.
  - Any state with flush -> EMPTY. Flush takes priority over load, and the offered ID entry is consumed and dropped.
- Forward function fwd(addr, rf):
  - If addr==0, result is rf. Register $0 is never forwarded.
  - Else if exmem_reg_write & exmem_rd_addr==addr, result is exmem_result (EX/MEM has priority).
  - Else if memwb_reg_write & memwb_rd_addr==addr, result is memwb_result.
  - Else rf.
- On load:
  - ex_a = fwd(id_rs_addr, id_rs_data).
  - ex_b = id_use_imm ? id_imm : fwd(id_rt_addr, id_rt_data).
  - ex_alu_op, ex_rd_addr and ex_reg_write are captured unchanged.
  - rs_addr, rt_addr and use_imm are latched internally.
- Snoop while held (FULL & !ex_ready & !flush):
  - ex_a updates to the forwarded value when a forwarding source matches the held rs (rs≠0).
  - ex_b updates the same way for held rt (rt≠0), unless use_imm.
  - Same EX/MEM-over-MEM/WB priority. Nothing else changes.
- Outputs hold their last values in EMPTY. Consumers qualify them with ex_valid.
- stall_cnt increments on each FULL & !ex_ready & !flush cycle and saturates at 2^CNTW-1. It is cleared only by reset.
- Opcodes are passed through unchecked. Undefined codes are the ALU's concern.

Decomposition:
- Shared package holds:
  - ALU opcode localparams (AND, OR, NOR, ADD, SUB, INC, MULTPLUS).
  - Widths NBITS, OPW, RAW.
  - Constant REG_ZERO=0.
- One natural sub-module, fwd_select: the combinational forward function, instantiated twice at load (A, B) and twice for snoop.

Test Plan:
- Basic capture: reset, then id_valid=1, alu_op=3 (ADD), rs=8 data=5, rt=9 data=7, no forwarding sources, ex_ready=1 -> next cycle ex_valid=1, ex_a=5, ex_b=7, ex_alu_op=3; stall_cnt=0.
- Forward priority: rs=8 with exmem_rd=8/result=0x100 and memwb_rd=8/result=0x200 both writing -> ex_a=0x100. Same with exmem_reg_write=0 -> ex_a=0x200. Same with rs=0 and rf=0 -> ex_a=0.
- Stall and snoop: load rs=10 (rf=1), ex_ready=0 for 3 cycles, memwb writes r10=0x55 in cycle 2 -> ex_a=0x55 from cycle 3, entry otherwise unchanged, id_ready=0, stall_cnt=3. Then ex_ready=1 -> consumed.
- Immediate: use_imm=1, imm=0xFFFFFFFC, exmem writes rt -> ex_b=0xFFFFFFFC (no forward on B).
- Flush/back-to-back: stream 4 entries with ex_ready=1 -> ex_valid continuous with no bubbles. Assert flush with id_valid=1 while FULL -> next cycle ex_valid=0, offered entry dropped.
- Reset mid-stall and saturation: reset while FULL stalled -> ex_valid=0, all ex_*=0, stall_cnt=0. With CNTW=4, stall 20 cycles -> stall_cnt=15.
